draw_layer_arbiter: RTL and testbench
=====================================

// Module: draw_layer_arbiter
// PURPOSE
//  Shares the single VGA RGB output between NUM_LAYERS object drawers, the border request and the background colour.
//  Selects one layer per pixel by fixed priority, honouring a transparent colour key; output is pipelined 2 cycles.
//  Accumulates per-layer overlap (collision) flags over a frame and publishes them at each startOfFrame.
//  Sits between the drawers (background, borders, sprites) and the VGA sync/DAC stage.
// PARAMETERS
//  NUM_LAYERS   4      object layers; index 0 = highest priority
//  RGB_W        8      colour width (3R:3G:2B)
//  TRANSPARENT  8'hFF  colour key: a request carrying this colour is ignored
//  BORDER_RGB   8'hFF  colour driven when boardersDrawReq wins (key check not applied)
// PORTS
//  clk              in   1                 pixel clock
//  reset            in   1                 asynchronous, active-high
//  pixelX           in   11                current pixel X (from timing gen)
//  pixelY           in   11                current pixel Y
//  startOfFrame     in   1                 1-cycle pulse, first pixel of a frame
//  layerDrawReq     in   NUM_LAYERS        per-layer draw request, bit i = layer i
//  layerRGB         in   NUM_LAYERS*RGB_W  per-layer colour, layer i at [i*RGB_W +: RGB_W]
//  boardersDrawReq  in   1                 border request (below all layers)
//  BG_RGB           in   RGB_W             background colour (lowest priority, always valid)
//  RGBOut           out  RGB_W             selected colour, 2 cycles after inputs
//  outX, outY       out  11 each           pixelX/pixelY delayed to align with RGBOut
//  winnerId         out  $clog2(NUM_LAYERS+2)  0..N-1 layer, N border, N+1 background
//  frameCollision   out  NUM_LAYERS        bit i: layer i overlapped another layer last frame
//  collisionPulse   out  1                 1-cycle pulse when frameCollision updated and nonzero
// BEHAVIOUR
//  - Reset: all outputs and pipeline regs 0; FSM -> WAIT_SOF.
//  - Stage 1 registers all inputs; stage 2 registers selection. Latency exactly 2 cycles, throughput 1 pixel/cycle.
//  - Layer i is active iff layerDrawReq[i] && layerRGB[i] != TRANSPARENT.
//  - Winner: lowest active i; else border if boardersDrawReq; else BG_RGB.
//  - Overlap: on any stage-1 cycle with >=2 active layers, OR those active bits into accumulator acc.
//  - FSM WAIT_SOF: acc held at 0, frameCollision 0; on startOfFrame -> ACTIVE (acc starts clear).
//  - FSM ACTIVE: on startOfFrame (seen at stage 1): frameCollision <= acc, collisionPulse <= |acc.
//    acc <= overlap of the current (SOF) pixel: the SOF pixel belongs to the new frame.
//  - Two SOFs with no overlap between them: frameCollision -> 0, no pulse.
//  - Reset mid-frame: pipeline flushed, FSM -> WAIT_SOF; the first frame after reset reports nothing until its closing SOF.
//  - Priority, transparency and winnerId are not affected by the FSM; RGB flows from the first cycle after reset.
// CONFIGURATION
//  - DRAW_ARB_COLLISION_EN defined: accumulator, FSM, frameCollision and collisionPulse as above.
//  - Not defined: no accumulator/FSM logic; frameCollision = 0, collisionPulse = 0.
//    RGB path, winnerId and latency are identical in both builds.
// STRUCTURE
//  - Package draw_arb_pkg: RGB_W and the rgb_t typedef; the TRANSPARENT default; the arb_state_t enum (WAIT_SOF, ACTIVE).
//  - Package also holds the winner-id width function.
//  - Sub-module draw_prio_select: combinational priority encoder (active vector -> index, valid, multi-active flag).
//  - draw_prio_select is instantiated in stage 1.
// TESTING
//  1. Layer1 req RGB 8'h1C, layer3 req 8'hE0, border req -> RGBOut 8'h1C, winnerId 1, 2 cycles later.
//  2. Layer0 req with RGB 8'hFF, layer2 8'h03 -> RGBOut 8'h03, winnerId 2 (key skipped).
//     Overlap flags stay 0 for this pixel (layer0 is not active).
//  3. No layer requests, border req -> RGBOut 8'hFF, winnerId N.
//     Nothing requested -> RGBOut = BG_RGB (8'h25), winnerId N+1.
//  4. SOF, then layers 0 and 2 overlap at (100,50), then SOF -> frameCollision 4'b0101, collisionPulse 1 for one cycle.
//     Next frame has no overlap; the following SOF -> frameCollision 0, no pulse.
//  5. Overlap of layers 1 and 3 on the SOF cycle itself -> not in the closing report.
//     That overlap appears as 4'b1010 at the next SOF.
//  6. Assert reset mid-frame after overlaps -> outputs 0 immediately; the first SOF after reset gives no pulse.
//     Build without DRAW_ARB_COLLISION_EN -> frameCollision stays 0; tests 1-3 unchanged.

Source files
------------

// File: rtl/draw_arb_pkg.sv
// Shared types for the draw layer arbiter: colour type, colour-key default,
// collision FSM states and the winner-id width helper.
package draw_arb_pkg;

  localparam int RGB_W = 8;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t TRANSPARENT_DEF = 8'hFF;
  localparam rgb_t BORDER_DEF      = 8'hFF;

  typedef enum logic {
    WAIT_SOF = 1'b0,
    ACTIVE   = 1'b1
  } arb_state_t;

  // Winner ids span layers 0..n-1, border n and background n+1
  function automatic int win_w(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/draw_layer_arbiter_prio.sv
// Fixed-priority encoder: lowest set bit wins; also flags when more than
// one bit is set so the caller can record an overlap.
module draw_prio_select #(
  parameter int N  = 4,
  parameter int IW = 3
) (
  input  logic [N-1:0]  i_act,
  output logic [IW-1:0] o_idx,
  output logic          o_valid,
  output logic          o_multi
);

  // Scan from the top so the lowest active index is the last write
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_act[i]) begin
        o_idx   = IW'(i);
        o_valid = 1'b1;
      end
    end
  end

  // Clearing the lowest set bit leaves something only if two or more were set
  assign o_multi = |(i_act & (i_act - N'(1)));

endmodule

// File: rtl/draw_layer_arbiter.sv
// Per-pixel layer arbiter with a 2-stage pipeline and optional per-frame
// collision reporting (enabled by defining DRAW_ARB_COLLISION_EN).
module draw_layer_arbiter
  import draw_arb_pkg::*;
#(
  parameter int   NUM_LAYERS  = 4,
  parameter rgb_t TRANSPARENT = TRANSPARENT_DEF,
  parameter rgb_t BORDER_RGB  = BORDER_DEF,
  localparam int  WID_W       = win_w(NUM_LAYERS)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [10:0]                 pixelX,
  input  logic [10:0]                 pixelY,
  input  logic                        startOfFrame,
  input  logic [NUM_LAYERS-1:0]       layerDrawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0] layerRGB,
  input  logic                        boardersDrawReq,
  input  logic [RGB_W-1:0]            BG_RGB,
  output logic [RGB_W-1:0]            RGBOut,
  output logic [10:0]                 outX,
  output logic [10:0]                 outY,
  output logic [WID_W-1:0]            winnerId,
  output logic [NUM_LAYERS-1:0]       frameCollision,
  output logic                        collisionPulse
);

  localparam logic [WID_W-1:0] ID_BORDER = WID_W'(NUM_LAYERS);
  localparam logic [WID_W-1:0] ID_BG     = WID_W'(NUM_LAYERS + 1);

  logic [10:0]                 r1_x;
  logic [10:0]                 r1_y;
  logic                        r1_sof;
  logic [NUM_LAYERS-1:0]       r1_req;
  logic [NUM_LAYERS*RGB_W-1:0] r1_rgb;
  logic                        r1_border;
  rgb_t                        r1_bg;

  logic [NUM_LAYERS-1:0] w_act;
  logic [WID_W-1:0]      w_idx;
  logic                  w_valid;
  logic                  w_multi;
  rgb_t                  w_sel_rgb;
  logic [WID_W-1:0]      w_sel_id;

  rgb_t             r2_rgb;
  logic [10:0]      r2_x;
  logic [10:0]      r2_y;
  logic [WID_W-1:0] r2_id;

  // Stage 1: register every input of the pixel
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r1_x      <= '0;
      r1_y      <= '0;
      r1_sof    <= 1'b0;
      r1_req    <= '0;
      r1_rgb    <= '0;
      r1_border <= 1'b0;
      r1_bg     <= '0;
    end else begin
      r1_x      <= pixelX;
      r1_y      <= pixelY;
      r1_sof    <= startOfFrame;
      r1_req    <= layerDrawReq;
      r1_rgb    <= layerRGB;
      r1_border <= boardersDrawReq;
      r1_bg     <= BG_RGB;
    end
  end

  // A request carrying the colour key does not count as drawing
  always_comb begin
    w_act = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      w_act[i] = r1_req[i] && (r1_rgb[i*RGB_W +: RGB_W] != TRANSPARENT);
    end
  end

  draw_prio_select #(
    .N  (NUM_LAYERS),
    .IW (WID_W)
  ) u_prio (
    .i_act   (w_act),
    .o_idx   (w_idx),
    .o_valid (w_valid),
    .o_multi (w_multi)
  );

  // Layer beats border, border beats background
  always_comb begin
    w_sel_rgb = r1_bg;
    w_sel_id  = ID_BG;
    if (w_valid) begin
      w_sel_rgb = r1_rgb[w_idx*RGB_W +: RGB_W];
      w_sel_id  = w_idx;
    end else if (r1_border) begin
      w_sel_rgb = BORDER_RGB;
      w_sel_id  = ID_BORDER;
    end
  end

  // Stage 2: register the selection with its coordinates
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r2_rgb <= '0;
      r2_x   <= '0;
      r2_y   <= '0;
      r2_id  <= '0;
    end else begin
      r2_rgb <= w_sel_rgb;
      r2_x   <= r1_x;
      r2_y   <= r1_y;
      r2_id  <= w_sel_id;
    end
  end

  assign RGBOut   = r2_rgb;
  assign outX     = r2_x;
  assign outY     = r2_y;
  assign winnerId = r2_id;

`ifdef DRAW_ARB_COLLISION_EN
  arb_state_t            r_state;
  logic [NUM_LAYERS-1:0] r_acc;
  logic [NUM_LAYERS-1:0] r_fc;
  logic                  r_pulse;
  logic [NUM_LAYERS-1:0] w_ovl;

  assign w_ovl = w_multi ? w_act : '0;

  // Frame tracker: accumulate overlaps, publish on each SOF.
  // The SOF pixel opens the new frame, so its overlap seeds the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= WAIT_SOF;
      r_acc   <= '0;
      r_fc    <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      unique case (r_state)
        WAIT_SOF: begin
          if (r1_sof) begin
            r_state <= ACTIVE;
            r_acc   <= w_ovl;
          end
        end
        ACTIVE: begin
          if (r1_sof) begin
            r_fc    <= r_acc;
            r_pulse <= |r_acc;
            r_acc   <= w_ovl;
          end else begin
            r_acc   <= r_acc | w_ovl;
          end
        end
        default: r_state <= WAIT_SOF;
      endcase
    end
  end

  assign frameCollision = r_fc;
  assign collisionPulse = r_pulse;
`else
  logic w_unused;

  assign w_unused       = ^{w_multi, r1_sof};
  assign frameCollision = '0;
  assign collisionPulse = 1'b0;
`endif

endmodule

// File: tb/tb_draw_layer_arbiter.sv
// Self-checking bench for draw_layer_arbiter: directed scenarios plus a
// randomized run against a per-pixel behavioural model.
module tb_draw_layer_arbiter;
  import draw_arb_pkg::*;

  localparam int N  = 4;
  localparam int WW = win_w(N);
`ifdef DRAW_ARB_COLLISION_EN
  localparam bit COLL = 1'b1;
`else
  localparam bit COLL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic [10:0]   pixelX, pixelY;
  logic          startOfFrame;
  logic [N-1:0]  layerDrawReq;
  logic [N*8-1:0] layerRGB;
  logic          boardersDrawReq;
  logic [7:0]    BG_RGB;
  logic [7:0]    RGBOut;
  logic [10:0]   outX, outY;
  logic [WW-1:0] winnerId;
  logic [N-1:0]  frameCollision;
  logic          collisionPulse;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0]    rgb;
    logic [WW-1:0] id;
    logic [10:0]   x;
    logic [10:0]   y;
    logic [N-1:0]  fc;
    logic          pl;
  } exp_t;

  exp_t         eq[$];
  bit           m_in_frame;
  logic [N-1:0] m_acc;
  logic [N-1:0] m_fc;

  draw_layer_arbiter #(.NUM_LAYERS(N)) dut (
    .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
    .startOfFrame(startOfFrame), .layerDrawReq(layerDrawReq),
    .layerRGB(layerRGB), .boardersDrawReq(boardersDrawReq),
    .BG_RGB(BG_RGB), .RGBOut(RGBOut), .outX(outX), .outY(outY),
    .winnerId(winnerId), .frameCollision(frameCollision),
    .collisionPulse(collisionPulse)
  );

  always #5 clk = ~clk;

  // Drive one pixel and record what the arbiter should produce for it
  task automatic setpx(input logic [N-1:0] req, input logic [N*8-1:0] rgbs,
                       input logic bd, input logic [7:0] bg,
                       input logic [10:0] x, input logic [10:0] y,
                       input logic sof);
    exp_t e;
    logic [N-1:0] act;
    bit found;
    layerDrawReq = req; layerRGB = rgbs; boardersDrawReq = bd;
    BG_RGB = bg; pixelX = x; pixelY = y; startOfFrame = sof;
    act = '0;
    for (int i = 0; i < N; i++) act[i] = req[i] && (rgbs[i*8 +: 8] != 8'hFF);
    found = 0;
    e.x = x; e.y = y; e.pl = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && act[i]) begin
        found = 1; e.rgb = rgbs[i*8 +: 8]; e.id = WW'(i);
      end
    end
    if (!found) begin
      e.rgb = bd ? 8'hFF : bg;
      e.id  = bd ? WW'(N) : WW'(N + 1);
    end
    if ($countones(act) < 2) act = '0;
    if (sof) begin
      if (m_in_frame) begin
        m_fc = m_acc;
        e.pl = (m_acc != 0);
      end
      m_in_frame = 1;
      m_acc = act;
    end else if (m_in_frame) begin
      m_acc = m_acc | act;
    end
    e.fc = COLL ? m_fc : '0;
    e.pl = COLL ? e.pl : 1'b0;
    eq.push_back(e);
  endtask

  task automatic idle_px();
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    layerDrawReq = '0; layerRGB = '0; boardersDrawReq = 1'b0;
    BG_RGB = 8'h25; pixelX = '0; pixelY = '0; startOfFrame = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    m_in_frame = 0; m_acc = '0; m_fc = '0;
    eq.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    layerDrawReq = '1; layerRGB = '1; boardersDrawReq = 1'b1;
    BG_RGB = 8'h25; pixelX = 11'd7; pixelY = 11'd9; startOfFrame = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (RGBOut !== 8'h00) begin bad++; $display("FAIL rst_rgb got %h want 00", RGBOut); end
    total++; if (winnerId !== '0) begin bad++; $display("FAIL rst_id got %0d want 0", winnerId); end
    total++; if (outX !== '0 || outY !== '0) begin bad++; $display("FAIL rst_xy got %0d,%0d want 0,0", outX, outY); end
    total++; if (frameCollision !== '0) begin bad++; $display("FAIL rst_fc got %b want 0", frameCollision); end
    total++; if (collisionPulse !== 1'b0) begin bad++; $display("FAIL rst_pulse got %b want 0", collisionPulse); end
    reset = 1'b0;
    m_in_frame = 0; m_acc = '0; m_fc = '0;
  endtask

  task automatic test_priority();
    idle_px(); @(negedge clk);
    idle_px(); @(negedge clk);
    setpx(4'b1010, {8'hE0, 8'h00, 8'h1C, 8'h00}, 1'b1, 8'h25, 11'd10, 11'd20, 1'b0);
    @(negedge clk);
    total++; if (RGBOut !== 8'h25) begin bad++; $display("FAIL lat1_rgb got %h want 25", RGBOut); end
    idle_px(); @(negedge clk);
    total++; if (RGBOut !== 8'h1C) begin bad++; $display("FAIL prio_rgb got %h want 1c", RGBOut); end
    total++; if (winnerId !== WW'(1)) begin bad++; $display("FAIL prio_id got %0d want 1", winnerId); end
    total++; if (outX !== 11'd10 || outY !== 11'd20) begin bad++; $display("FAIL prio_xy got %0d,%0d want 10,20", outX, outY); end
  endtask

  task automatic test_transparent();
    setpx(4'b0101, {8'h00, 8'h03, 8'h00, 8'hFF}, 1'b0, 8'h25, 11'd1, 11'd2, 1'b0);
    @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (RGBOut !== 8'h03) begin bad++; $display("FAIL key_rgb got %h want 03", RGBOut); end
    total++; if (winnerId !== WW'(2)) begin bad++; $display("FAIL key_id got %0d want 2", winnerId); end
  endtask

  task automatic test_border_bg();
    setpx('0, '0, 1'b1, 8'h25, 11'd3, 11'd4, 1'b0);
    @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (RGBOut !== 8'hFF) begin bad++; $display("FAIL bd_rgb got %h want ff", RGBOut); end
    total++; if (winnerId !== WW'(N)) begin bad++; $display("FAIL bd_id got %0d want %0d", winnerId, N); end
    @(negedge clk);
    total++; if (RGBOut !== 8'h25) begin bad++; $display("FAIL bg_rgb got %h want 25", RGBOut); end
    total++; if (winnerId !== WW'(N + 1)) begin bad++; $display("FAIL bg_id got %0d want %0d", winnerId, N + 1); end
  endtask

  task automatic test_collision();
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1); @(negedge clk);
    setpx(4'b0101, {8'h00, 8'h20, 8'h00, 8'h10}, 1'b0, 8'h25, 11'd100, 11'd50, 1'b0);
    @(negedge clk);
    idle_px(); @(negedge clk);
    idle_px(); @(negedge clk);
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1); @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (frameCollision !== (COLL ? 4'b0101 : 4'b0000)) begin bad++; $display("FAIL coll_fc got %b want %b", frameCollision, COLL ? 4'b0101 : 4'b0000); end
    total++; if (collisionPulse !== COLL) begin bad++; $display("FAIL coll_pulse got %b want %b", collisionPulse, COLL); end
    @(negedge clk);
    total++; if (collisionPulse !== 1'b0) begin bad++; $display("FAIL coll_pulse_len got %b want 0", collisionPulse); end
    total++; if (frameCollision !== (COLL ? 4'b0101 : 4'b0000)) begin bad++; $display("FAIL coll_hold got %b", frameCollision); end
    idle_px(); @(negedge clk);
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1); @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (frameCollision !== 4'b0000) begin bad++; $display("FAIL clean_fc got %b want 0000", frameCollision); end
    total++; if (collisionPulse !== 1'b0) begin bad++; $display("FAIL clean_pulse got %b want 0", collisionPulse); end
  endtask

  task automatic test_sof_overlap();
    setpx(4'b1010, {8'h33, 8'h00, 8'h11, 8'h00}, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1);
    @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (frameCollision !== 4'b0000 || collisionPulse !== 1'b0) begin bad++; $display("FAIL sofov_close got %b/%b want 0000/0", frameCollision, collisionPulse); end
    idle_px(); @(negedge clk);
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1); @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (frameCollision !== (COLL ? 4'b1010 : 4'b0000)) begin bad++; $display("FAIL sofov_next got %b want %b", frameCollision, COLL ? 4'b1010 : 4'b0000); end
    total++; if (collisionPulse !== COLL) begin bad++; $display("FAIL sofov_pulse got %b want %b", collisionPulse, COLL); end
  endtask

  task automatic test_reset_mid();
    setpx(4'b0011, {8'h00, 8'h00, 8'h02, 8'h01}, 1'b0, 8'h25, 11'd5, 11'd6, 1'b0);
    @(negedge clk);
    idle_px(); @(negedge clk);
    reset = 1'b1;
    #1;
    total++; if (RGBOut !== 8'h00 || winnerId !== '0) begin bad++; $display("FAIL mid_rst_rgb got %h/%0d want 00/0", RGBOut, winnerId); end
    total++; if (frameCollision !== '0 || collisionPulse !== 1'b0) begin bad++; $display("FAIL mid_rst_fc got %b/%b want 0/0", frameCollision, collisionPulse); end
    @(negedge clk);
    reset = 1'b0;
    m_in_frame = 0; m_acc = '0; m_fc = '0;
    setpx(4'b0011, {8'h00, 8'h00, 8'h02, 8'h01}, 1'b0, 8'h25, 11'd5, 11'd6, 1'b0);
    @(negedge clk);
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1); @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (frameCollision !== '0 || collisionPulse !== 1'b0) begin bad++; $display("FAIL first_sof got %b/%b want 0/0", frameCollision, collisionPulse); end
    setpx(4'b1100, {8'h44, 8'h55, 8'h00, 8'h00}, 1'b0, 8'h25, 11'd8, 11'd9, 1'b0);
    @(negedge clk);
    setpx('0, '0, 1'b0, 8'h25, 11'd0, 11'd0, 1'b1); @(negedge clk);
    idle_px(); @(negedge clk);
    total++; if (frameCollision !== (COLL ? 4'b1100 : 4'b0000)) begin bad++; $display("FAIL second_sof got %b want %b", frameCollision, COLL ? 4'b1100 : 4'b0000); end
  endtask

  task automatic test_random();
    exp_t e;
    logic [N*8-1:0] rgbs;
    logic [N-1:0] req;
    logic sof;
    do_reset();
    for (int k = 0; k < 400; k++) begin
      if (eq.size() == 2) begin
        e = eq.pop_front();
        total++; if (RGBOut !== e.rgb) begin bad++; $display("FAIL rnd_rgb k=%0d got %h want %h", k, RGBOut, e.rgb); end
        total++; if (winnerId !== e.id) begin bad++; $display("FAIL rnd_id k=%0d got %0d want %0d", k, winnerId, e.id); end
        total++; if (outX !== e.x || outY !== e.y) begin bad++; $display("FAIL rnd_xy k=%0d got %0d,%0d want %0d,%0d", k, outX, outY, e.x, e.y); end
        total++; if (frameCollision !== e.fc) begin bad++; $display("FAIL rnd_fc k=%0d got %b want %b", k, frameCollision, e.fc); end
        total++; if (collisionPulse !== e.pl) begin bad++; $display("FAIL rnd_pulse k=%0d got %b want %b", k, collisionPulse, e.pl); end
      end
      sof = ($urandom_range(0, 15) == 0);
      req = N'($urandom);
      if (sof && !m_in_frame) req = '0;
      for (int i = 0; i < N; i++)
        rgbs[i*8 +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      setpx(req, rgbs, 1'($urandom), 8'($urandom), 11'($urandom), 11'($urandom), sof);
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_transparent();
    test_border_bg();
    test_collision();
    test_sof_overlap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
